// File: rtl/ddr_less_frame_deserializer.sv
// Serial frame deserializer: start | addr (MSB first) | data (MSB first) | [parity] | stop.
// Define FRAME_PARITY_EN to add an even-parity bit after the data field.
//
// state  | meaning
// IDLE   | waiting for a start bit (sda=1 on an enabled edge)
// SHIFT  | collecting ADDR_W+DATA_W address/data bits
// PARITY | capturing the parity bit (FRAME_PARITY_EN only)
// STOP   | checking the stop bit and publishing or rejecting the frame
module ddr_less_frame_deserializer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              sda,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int TOT  = ADDR_W + DATA_W;
  localparam int BC_W = $clog2(TOT + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(TOT - 1);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TOT-1:0]    shift_q, shift_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [15:0]       to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              par_err;

`ifdef FRAME_PARITY_EN
  logic par_q, par_d;
  // Even parity over address, data and the parity bit itself.
  assign par_err = ^{shift_q, par_q};
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
`ifdef FRAME_PARITY_EN
    par_d     = par_q;
`endif
    if (state_q == S_IDLE) begin
      to_cnt_d = '0;
      if (en && sda) begin
        state_d   = S_SHIFT;
        bit_cnt_d = '0;
      end
    end else if (!en) begin
      // Stalled mid-frame: everything holds except the stall counter.
      if (to_cnt_q == TO_LAST) begin
        err_d    = 1'b1;
        state_d  = S_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 16'd1;
      end
    end else begin
      to_cnt_d = '0;
      case (state_q)
        S_SHIFT: begin
          shift_d   = {shift_q[TOT-2:0], sda};
          bit_cnt_d = bit_cnt_q + BC_ONE;
          if (bit_cnt_q == BC_LAST) begin
`ifdef FRAME_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef FRAME_PARITY_EN
        S_PARITY: begin
          par_d   = sda;
          state_d = S_STOP;
        end
`endif
        S_STOP: begin
          state_d = S_IDLE;
          if (!sda && !par_err) begin
            valid_d = 1'b1;
            addr_d  = shift_q[TOT-1 -: ADDR_W];
            data_d  = shift_q[DATA_W-1:0];
            cnt_d   = cnt_q + CNT_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FRAME_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef FRAME_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign addr_out  = addr_q;
  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = busy_q;
  assign frame_cnt = cnt_q;

endmodule
